// File: rtl/rnd_harvester.sv
// rnd_harvester: drives a latch-based random generator through
// excite/settle/sample rounds and packs the sampled bits LSB-first into bytes.
// Completed bytes are queued in a 2-entry FIFO with a valid/ready output.
// Optional feature: define RND_HARVESTER_VN_EN to enable von Neumann
// debiasing (sample pairs 01 -> 0, 10 -> 1, 00/11 discarded and counted).
// Without the macro every sample is accepted and discard_cnt is tied to 0.
module rnd_harvester #(
  parameter int EXCITE_CYCLES = 2,  // 1..15
  parameter int SETTLE_CYCLES = 3   // 2..15, covers latch settling and sync
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       raw_in,
  output logic       gen_freeze,
  output logic [7:0] rnd_data,
  output logic       rnd_valid,
  input  logic       rnd_ready,
  output logic [7:0] discard_cnt
);

  typedef enum logic [1:0] {IDLE, EXCITE, SETTLE, SAMPLE} state_t;

  state_t     state, state_next;
  logic [3:0] phase_cnt, phase_cnt_next;

  logic       sync1, sync2;

  logic [7:0] acc;
  logic [2:0] bit_cnt;
  logic       accept;
  logic       accept_bit;

  logic [7:0] fifo_mem0, fifo_mem1;   // fifo_mem0 is always the head
  logic [1:0] fifo_count, count_next;
  logic       push, pop;
  logic [7:0] push_data;

  // Two-flop synchronizer: raw_in is asynchronous to clk.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // FSM state and per-phase cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_cnt_next;
    end
  end

  // Next-state logic; the generator is frozen everywhere except EXCITE.
  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips an assignment infers a latch.
  always_comb begin
    state_next     = state;
    phase_cnt_next = phase_cnt;
    gen_freeze     = 1'b1;
    case (state)
      IDLE: begin
        phase_cnt_next = '0;
        if (enable && (fifo_count < 2'd2)) state_next = EXCITE;
      end
      EXCITE: begin
        gen_freeze = 1'b0;
        if (phase_cnt == 4'(EXCITE_CYCLES - 1)) begin
          state_next     = SETTLE;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt + 4'd1;
        end
      end
      SETTLE: begin
        if (phase_cnt == 4'(SETTLE_CYCLES - 1)) begin
          state_next     = SAMPLE;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        // A round is never aborted; the decision to continue is made here,
        // using the FIFO occupancy that will exist after this cycle.
        phase_cnt_next = '0;
        if (enable && (count_next < 2'd2)) state_next = EXCITE;
        else                               state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef RND_HARVESTER_VN_EN
  logic pair_pending;
  logic pair_first;
  logic pair_discard;

  // Von Neumann decision: the second sample of a pair decides accept/discard.
  always_comb begin
    accept       = 1'b0;
    accept_bit   = pair_first;
    pair_discard = 1'b0;
    if (state == SAMPLE && pair_pending) begin
      if (pair_first != sync2) accept       = 1'b1;
      else                     pair_discard = 1'b1;
    end
  end

  // Pair tracking and saturating discard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_pending <= 1'b0;
      pair_first   <= 1'b0;
      discard_cnt  <= '0;
    end else begin
      if (state == SAMPLE) begin
        if (!pair_pending) begin
          pair_first   <= sync2;
          pair_pending <= 1'b1;
        end else begin
          pair_pending <= 1'b0;
        end
      end
      if (pair_discard && discard_cnt != 8'hFF) discard_cnt <= discard_cnt + 8'd1;
    end
  end
`else
  // Raw mode: every sample is taken as-is.
  always_comb begin
    accept     = (state == SAMPLE);
    accept_bit = sync2;
  end

  assign discard_cnt = 8'h00;
`endif

  // The eighth accepted bit completes a byte and pushes it the same cycle.
  assign push      = accept && (bit_cnt == 3'd7);
  assign push_data = {accept_bit, acc[7:1]};
  assign pop       = rnd_valid && rnd_ready;

  // Bit accumulator: shift right so the first accepted bit ends up in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      acc     <= push_data;
      bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 on the push
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 2'd1;
      2'b01:   count_next = fifo_count - 2'd1;
      default: count_next = fifo_count;
    endcase
  end

  // Two-entry FIFO with the head fixed in fifo_mem0; a pop shifts entry 1 up.
  // NOTE: the storage is reset (not left undefined) because rnd_data is the
  // head register itself and must read 8'h00 while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem0  <= '0;
      fifo_mem1  <= '0;
      fifo_count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) fifo_mem0 <= push_data;
          else                    fifo_mem1 <= push_data;
        end
        2'b01: fifo_mem0 <= fifo_mem1;
        2'b11: begin
          if (fifo_count == 2'd1) begin
            fifo_mem0 <= push_data;
          end else begin
            fifo_mem0 <= fifo_mem1;
            fifo_mem1 <= push_data;
          end
        end
        default: ;
      endcase
      fifo_count <= count_next;
    end
  end

  assign rnd_valid = (fifo_count != 2'd0);
  assign rnd_data  = fifo_mem0;

endmodule

// File: tb/tb_rnd_harvester.sv
// tb_rnd_harvester: directed bench for rnd_harvester (default parameters).
// The raw bit for each round is applied on the first EXCITE cycle and held
// for the whole round, so the synchronized sample seen in SAMPLE is that bit.
module tb_rnd_harvester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       raw_in = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       gen_freeze;
  logic       rnd_valid;
  logic [7:0] rnd_data;
  logic [7:0] discard_cnt;

  int total = 0;
  int bad   = 0;

  rnd_harvester dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .raw_in     (raw_in),
    .gen_freeze (gen_freeze),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .discard_cnt(discard_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst       = 1'b1;
    enable    = 1'b0;
    rnd_ready = 1'b0;
    raw_in    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Wait for the next round start (falling gen_freeze), then apply the bit.
  task automatic feed_bit(input logic b);
    logic prev;
    bit   found;
    prev  = gen_freeze;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev && !gen_freeze) begin
        raw_in = b;
        found  = 1'b1;
      end
      prev = gen_freeze;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL feed_bit: no round start in 40 cycles, got gen_freeze=%b want a falling edge", gen_freeze);
    end
  endtask

  task automatic feed_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) feed_bit(v[i]);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!rnd_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!rnd_valid) begin
      total++;
      bad++;
      $display("FAIL %s: rnd_valid got 0 want 1 within 80 cycles", name);
    end
  endtask

  task automatic pop_one;
    rnd_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [2:0] exp_freeze;
    logic [7:0] pat;
    exp_freeze = 3'b100;
    pat        = 8'hA5;
    rst = 1'b1; enable = 1'b0; rnd_ready = 1'b0; raw_in = 1'b0;
    @(negedge clk);
    total++; if (gen_freeze !== 1'b1) begin bad++; $display("FAIL rst_freeze: got %b want 1", gen_freeze); end
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", rnd_valid); end
    total++; if (rnd_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", rnd_data); end
    total++; if (discard_cnt !== 8'h00) begin bad++; $display("FAIL rst_discard: got %h want 00", discard_cnt); end

    // Run a partial byte, then reset in the second EXCITE cycle of round 5.
    rst = 1'b0;
    enable = 1'b1;
    repeat (5) feed_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (gen_freeze !== 1'b1) begin bad++; $display("FAIL midrst_freeze: got %b want 1", gen_freeze); end
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", rnd_valid); end
    total++; if (discard_cnt !== 8'h00) begin bad++; $display("FAIL midrst_discard: got %h want 00", discard_cnt); end
    @(negedge clk);
    rst = 1'b0;

    // The first cycle after release goes IDLE -> EXCITE with a full EXCITE.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) raw_in = pat[0];
      total++;
      if (gen_freeze !== exp_freeze[i]) begin
        bad++;
        $display("FAIL restart_freeze[%0d]: got %b want %b", i, gen_freeze, exp_freeze[i]);
      end
    end
`ifndef RND_HARVESTER_VN_EN
    // The discarded partial byte must not leak into the next byte.
    for (int i = 1; i < 8; i++) feed_bit(pat[i]);
    wait_valid("restart_byte");
    total++; if (rnd_data !== 8'hA5) begin bad++; $display("FAIL restart_byte: got %h want a5", rnd_data); end
    pop_one();
`endif
    enable = 1'b0;
  endtask

`ifndef RND_HARVESTER_VN_EN
  task automatic test_pattern;
    logic [11:0] exp_freeze;
    logic [7:0]  bits;
    exp_freeze = 12'hF3C;  // per-cycle, bit 0 first: 0,0,1,1,1,1 repeated
    bits       = 8'h4D;    // raw sequence 1,0,1,1,0,0,1,0
    do_reset();
    enable = 1'b1;
    feed_bit(bits[0]);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 6) raw_in = bits[1];
      total++;
      if (gen_freeze !== exp_freeze[i]) begin
        bad++;
        $display("FAIL round_freeze[%0d]: got %b want %b", i, gen_freeze, exp_freeze[i]);
      end
    end
    for (int i = 2; i < 8; i++) feed_bit(bits[i]);
    wait_valid("byte_4d");
    total++; if (rnd_data !== 8'h4D) begin bad++; $display("FAIL byte_4d: got %h want 4d", rnd_data); end
    total++; if (discard_cnt !== 8'h00) begin bad++; $display("FAIL raw_discard: got %h want 00", discard_cnt); end
    pop_one();
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL after_pop_valid: got %b want 0", rnd_valid); end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop;
    logic [7:0] v;
    bit         ok;
    v = 8'h3C;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) feed_bit(v[i]);
    repeat (2) @(negedge clk);   // now in the first SETTLE cycle of round 4
    enable = 1'b0;
    repeat (3) @(negedge clk);   // remaining SETTLE cycles and SAMPLE
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gen_freeze !== 1'b1 || rnd_valid !== 1'b0) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL drop_idle: got freeze=%b valid=%b want parked freeze=1 valid=0", gen_freeze, rnd_valid); end
    enable = 1'b1;
    for (int i = 4; i < 8; i++) feed_bit(v[i]);
    wait_valid("drop_byte");
    total++; if (rnd_data !== 8'h3C) begin bad++; $display("FAIL drop_byte: got %h want 3c", rnd_data); end
    pop_one();
    enable = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    int n;
    do_reset();
    enable = 1'b1;
    feed_byte(8'h96);
    feed_byte(8'h5A);
    repeat (6) @(negedge clk);   // past SAMPLE of round 16
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gen_freeze !== 1'b1 || rnd_valid !== 1'b1) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL full_park: got freeze=%b valid=%b want 1/1", gen_freeze, rnd_valid); end
    total++; if (rnd_data !== 8'h96) begin bad++; $display("FAIL full_head: got %h want 96", rnd_data); end
    pop_one();
    n = 0;
    while (gen_freeze && n < 4) begin
      @(negedge clk);
      n++;
    end
    total++; if (gen_freeze !== 1'b0) begin bad++; $display("FAIL pop_restart: got freeze=%b want 0 within 4 cycles", gen_freeze); end
    total++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h5A) begin bad++; $display("FAIL full_second: got valid=%b data=%h want 1/5a", rnd_valid, rnd_data); end
    pop_one();
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", rnd_valid); end
    enable = 1'b0;
  endtask

  task automatic test_push_pop;
    do_reset();
    enable = 1'b1;
    feed_byte(8'hC3);
    feed_byte(8'h81);            // back in EXCITE of round 16
    repeat (5) @(negedge clk);   // SAMPLE cycle of round 16
    total++; if (rnd_valid !== 1'b1 || rnd_data !== 8'hC3) begin bad++; $display("FAIL pp_head: got valid=%b data=%h want 1/c3", rnd_valid, rnd_data); end
    rnd_ready = 1'b1;            // pop coincides with the push of 8'h81
    @(negedge clk);
    total++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h81) begin bad++; $display("FAIL pp_next: got valid=%b data=%h want 1/81", rnd_valid, rnd_data); end
    rnd_ready = 1'b0;
    @(negedge clk);
    total++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h81) begin bad++; $display("FAIL pp_hold: got valid=%b data=%h want 1/81", rnd_valid, rnd_data); end
    rnd_ready = 1'b1;
    @(negedge clk);
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL pp_empty: got %b want 0", rnd_valid); end
    rnd_ready = 1'b0;
    enable = 1'b0;
  endtask
`else
  task automatic test_vn;
    int samples [20] = '{0,1, 1,1, 1,0, 0,0, 1,0, 0,1, 0,1, 1,0, 1,0, 1,0};
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) feed_bit(samples[i][0]);
    wait_valid("vn_byte");
    total++; if (rnd_data !== 8'hE6) begin bad++; $display("FAIL vn_byte: got %h want e6", rnd_data); end
    total++; if (discard_cnt !== 8'd2) begin bad++; $display("FAIL vn_discard: got %0d want 2", discard_cnt); end
    pop_one();
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifndef RND_HARVESTER_VN_EN
    test_pattern();
    test_enable_drop();
    test_backpressure();
    test_push_pop();
`else
    test_vn();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rnd_harvester.md
RND_HARVESTER -- requirements
Module: rnd_harvester

Interface
REQ-001 Parameter EXCITE_CYCLES, default 2: cycles gen_freeze is held low per round; legal range 1..15.
REQ-002 Parameter SETTLE_CYCLES, default 3: cycles after gen_freeze rises before sampling; covers latch resolution and the 2-flop synchronizer; legal range 2..15.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = run harvest rounds; 0 = stop after the current round completes.
REQ-006 raw_in  input  1  raw bit from the latch-based random generator; asynchronous to clk.
REQ-007 gen_freeze  output  1  drives generator G: 0 = random/excite, 1 = freeze/hold.
REQ-008 rnd_data  output  8  harvested byte at FIFO head.
REQ-009 rnd_valid  output  1  rnd_data holds a byte.
REQ-010 rnd_ready  input  1  consumer accepts; transfer occurs when rnd_valid & rnd_ready are both 1 on a clk edge.
REQ-011 discard_cnt  output  8  count of rejected samples/pairs; saturates at 255.

Function
REQ-012 raw_in SHALL pass through a 2-flop synchronizer before any use.
REQ-013 FSM states SHALL be IDLE, EXCITE, SETTLE, SAMPLE.
REQ-014 IDLE: gen_freeze=1; go to EXCITE when enable=1 and FIFO count < 2.
REQ-015 EXCITE: gen_freeze=0 for exactly EXCITE_CYCLES cycles, then SETTLE.
REQ-016 SETTLE: gen_freeze=1 for exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-017 SAMPLE: one cycle; capture the synchronized bit; gen_freeze=1; next state is EXCITE if enable=1 and FIFO count < 2 (counting any push made this cycle), else IDLE.
REQ-018 A round SHALL be EXCITE_CYCLES+SETTLE_CYCLES+1 cycles; defaults give 6 cycles.
REQ-019 enable falling mid-round SHALL NOT abort the round; the FSM completes SAMPLE, then enters IDLE; a partial byte is retained.
REQ-020 Each accepted bit SHALL shift into an 8-bit accumulator LSB-first; the 8th accepted bit pushes the completed byte into the FIFO in the same cycle and clears the bit count.
REQ-021 Output FIFO SHALL be 2 entries, first in first out; rnd_valid = (count != 0); rnd_data = head entry.
REQ-022 Push and pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-023 Overflow is impossible: rounds never start with count = 2, and at most one push occurs per round.
REQ-024 rnd_data SHALL remain stable while rnd_valid=1 and rnd_ready=0.

Reset
REQ-025 While rst=1: state IDLE, gen_freeze=1, FIFO empty, rnd_valid=0, rnd_data=8'h00, accumulator and bit count cleared, VN pair flag cleared, discard_cnt=0, synchronizer flops 0.
REQ-026 A reset asserted mid-round SHALL discard the partial byte and any pending pair immediately; after release, behaviour is identical to power-up.

Configuration
REQ-027 Macro RND_HARVESTER_VN_EN SHALL select von Neumann debiasing.
REQ-028 With RND_HARVESTER_VN_EN defined:
  - samples are paired: first sample stored, second compared;
  - 01 accepts bit 0; 10 accepts bit 1;
  - 00 and 11 are discarded, discard_cnt += 1;
  - a byte needs 16 or more rounds.
REQ-029 Without the macro:
  - every sample is accepted directly;
  - a byte completes every 8 rounds;
  - discard_cnt is tied to 0.

Verification
REQ-030 Reset with rst=1 mid-EXCITE: gen_freeze goes to 1 immediately, rnd_valid=0, discard_cnt=0; after release with enable=1, EXCITE restarts from cycle 0.
REQ-031 Defaults, enable=1, no VN: gen_freeze pattern per round is low 2 cycles, then high 4 cycles. raw_in sequence 1,0,1,1,0,0,1,0 yields rnd_data=8'h4D after 8 rounds plus sync latency.
REQ-032 VN build, sample pairs 01,11,10,00,10,01,01,10,10,10 yields accepted bits 0,1,1,0,0,1,1,1 to byte 8'hE6, discard_cnt=2.
REQ-033 rnd_ready=0 held: exactly 2 bytes queue, FSM parks in IDLE with gen_freeze=1; one pop restarts rounds on the next cycle.
REQ-034 enable dropped during SETTLE: SAMPLE still occurs, then IDLE; partial byte count is kept and completes correctly after enable returns to 1.
REQ-035 rnd_ready toggled every cycle with FIFO count 1 and a push coincident with a pop: order preserved, no byte lost or duplicated.
